// File: rtl/dbus_arbiter.sv
// rtl/dbus_arbiter.sv - data-bus arbiter: J1 core at top priority, masters A/B round-robin in free slots
module dbus_arbiter #(
   parameter int AW = 16,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] c_adr,
   input  logic          c_re,
   input  logic          c_we,
   input  logic [DW-1:0] c_dat_o,
   output logic [DW-1:0] c_dat_i,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_adr,
   input  logic [DW-1:0] a_dat_o,
   output logic [DW-1:0] a_dat_i,
   output logic          a_ack,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_adr,
   input  logic [DW-1:0] b_dat_o,
   output logic [DW-1:0] b_dat_i,
   output logic          b_ack,
   output logic [AW-1:0] m_adr,
   output logic          m_re,
   output logic          m_we,
   output logic [DW-1:0] m_dat_o,
   input  logic [DW-1:0] m_dat_i,
   output logic [1:0]    m_owner
);

   // Owner of the previous slot, i.e. who the slave's read data belongs to this cycle.
   typedef enum logic [1:0] {IDLE, C_RESP, A_RESP, B_RESP} resp_t;

   resp_t state;
   logic  a_ack_q;
   logic  b_ack_q;
   logic  rr_b;       // 0: A wins the next contested slot, 1: B wins it
   logic  core_sel;
   logic  a_elig;
   logic  b_elig;
   logic  grant_a;
   logic  grant_b;

   // Slot decision: core first; a master in its ack cycle sits out so it cannot be granted twice.
   always_comb begin
      core_sel = ~reset & (c_re | c_we);
      a_elig   = ~reset & a_req & ~a_ack_q;
      b_elig   = ~reset & b_req & ~b_ack_q;
      grant_a  = ~core_sel & a_elig & (~b_elig | ~rr_b);
      grant_b  = ~core_sel & b_elig & (~a_elig |  rr_b);
   end

   // Slave-side mux; the core path is a pure pass-through so it adds no latency.
   always_comb begin
      m_adr   = c_adr;
      m_dat_o = c_dat_o;
      m_re    = 1'b0;
      m_we    = 1'b0;
      m_owner = 2'd0;
      if (core_sel) begin
         m_re    = c_re;
         m_we    = c_we;
         m_owner = 2'd1;
      end else if (grant_a) begin
         m_adr   = a_adr;
         m_dat_o = a_dat_o;
         m_re    = ~a_we;
         m_we    = a_we;
         m_owner = 2'd2;
      end else if (grant_b) begin
         m_adr   = b_adr;
         m_dat_o = b_dat_o;
         m_re    = ~b_we;
         m_we    = b_we;
         m_owner = 2'd3;
      end
   end

   // Response routing; a reset landing in the ack cycle suppresses that ack outright.
   always_comb begin
      c_dat_i = m_dat_i;
      a_dat_i = (state == A_RESP) ? m_dat_i : '0;
      b_dat_i = (state == B_RESP) ? m_dat_i : '0;
      a_ack   = a_ack_q & ~reset;
      b_ack   = b_ack_q & ~reset;
   end

   // Response state, pending acks and round-robin pointer (flips only on a contested grant).
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         a_ack_q <= 1'b0;
         b_ack_q <= 1'b0;
         rr_b    <= 1'b0;
      end else begin
         if (core_sel)     state <= C_RESP;
         else if (grant_a) state <= A_RESP;
         else if (grant_b) state <= B_RESP;
         else              state <= IDLE;
         a_ack_q <= grant_a;
         b_ack_q <= grant_b;
         if (grant_a && b_elig) rr_b <= 1'b1;
         if (grant_b && a_elig) rr_b <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb/tb_dbus_arbiter.sv - randomized scoreboard bench for dbus_arbiter
module tb_dbus_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] c_adr, c_dat_o, c_dat_i;
   logic        c_re, c_we;
   logic        a_req, a_we, a_ack, b_req, b_we, b_ack;
   logic [15:0] a_adr, a_dat_o, a_dat_i, b_adr, b_dat_o, b_dat_i;
   logic [15:0] m_adr, m_dat_o;
   logic [15:0] m_dat_i = 16'h0;
   logic        m_re, m_we;
   logic [1:0]  m_owner;

   dbus_arbiter #(.AW(16), .DW(16)) dut (
      .clk(clk), .reset(reset),
      .c_adr(c_adr), .c_re(c_re), .c_we(c_we), .c_dat_o(c_dat_o), .c_dat_i(c_dat_i),
      .a_req(a_req), .a_we(a_we), .a_adr(a_adr), .a_dat_o(a_dat_o), .a_dat_i(a_dat_i), .a_ack(a_ack),
      .b_req(b_req), .b_we(b_we), .b_adr(b_adr), .b_dat_o(b_dat_o), .b_dat_i(b_dat_i), .b_ack(b_ack),
      .m_adr(m_adr), .m_re(m_re), .m_we(m_we), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_owner(m_owner)
   );

   always #5 clk = ~clk;

   typedef struct {int cyc; logic [1:0] owner; logic re; logic we; logic [15:0] adr; logic [15:0] dat;} bus_t;
   typedef struct {int cyc; logic rd; logic [15:0] dat;} rsp_t;

   bus_t        bus_q[$];
   rsp_t        a_q[$];
   rsp_t        b_q[$];
   rsp_t        c_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic        run = 1'b0;
   logic [15:0] mem [64];
   logic [15:0] shadow [64];

   always @(posedge clk) cyc <= cyc + 1;

   // Single-port slave with a registered read.
   always @(posedge clk) begin
      if (m_we) mem[m_adr[5:0]] <= m_dat_o;
      if (m_re) m_dat_i <= mem[m_adr[5:0]];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic check_ack(input string name, input logic ack, input logic [15:0] dat, inout rsp_t q[$]);
      while (q.size() > 0 && q[0].cyc < cyc) begin
         chk({name, "_missing"}, 32'd0, 32'd1);
         void'(q.pop_front());
      end
      if (ack) begin
         if (q.size() == 0 || q[0].cyc != cyc) begin
            chk({name, "_unexpected"}, 32'd1, 32'd0);
         end else begin
            chk({name, "_ack"}, 32'd1, 32'd1);
            if (q[0].rd) chk({name, "_data"}, {16'h0, dat}, {16'h0, q[0].dat});
            void'(q.pop_front());
         end
      end
   endtask

   // Monitor: consumes expectations whenever the DUT strobes the slave or acks a master.
   always @(negedge clk) begin
      if (run) begin
         while (bus_q.size() > 0 && bus_q[0].cyc < cyc) begin
            chk("strobe_missing", {16'h0, bus_q[0].adr}, 32'hffffffff);
            void'(bus_q.pop_front());
         end
         if (m_re || m_we) begin
            if (bus_q.size() == 0 || bus_q[0].cyc != cyc) begin
               chk("strobe_unexpected", {14'h0, m_owner, m_adr}, 32'h0);
            end else begin
               chk("owner", {30'h0, m_owner}, {30'h0, bus_q[0].owner});
               chk("re_we", {30'h0, m_re, m_we}, {30'h0, bus_q[0].re, bus_q[0].we});
               chk("adr", {16'h0, m_adr}, {16'h0, bus_q[0].adr});
               if (bus_q[0].we) chk("wdata", {16'h0, m_dat_o}, {16'h0, bus_q[0].dat});
               void'(bus_q.pop_front());
            end
         end else if (m_owner != 2'd0) begin
            chk("owner_idle", {30'h0, m_owner}, 32'h0);
         end
         check_ack("a", a_ack, a_dat_i, a_q);
         check_ack("b", b_ack, b_dat_i, b_q);
         while (c_q.size() > 0 && c_q[0].cyc < cyc) void'(c_q.pop_front());
         if (c_q.size() > 0 && c_q[0].cyc == cyc) begin
            chk("core_rdata", {16'h0, c_dat_i}, {16'h0, c_q[0].dat});
            void'(c_q.pop_front());
         end
      end
   end

   // Master-side stimulus state and the reference model of the slot rules.
   logic        req [2];
   logic        xwe [2];
   logic [15:0] xadr [2];
   logic [15:0] xdat [2];
   logic        pend [2];
   logic        ackd_prev [2];
   logic        rr;
   logic        core_prev;

   always_comb begin
      a_req = req[0]; a_we = xwe[0]; a_adr = xadr[0]; a_dat_o = xdat[0];
      b_req = req[1]; b_we = xwe[1]; b_adr = xadr[1]; b_dat_o = xdat[1];
   end

   task automatic push_bus(input logic [1:0] owner, input logic re, input logic we,
                           input logic [15:0] adr, input logic [15:0] dat);
      bus_t e;
      e.cyc = cyc; e.owner = owner; e.re = re; e.we = we; e.adr = adr; e.dat = dat;
      bus_q.push_back(e);
      if (we) shadow[adr[5:0]] = dat;
   endtask

   task automatic step(input logic quiet);
      rsp_t r;
      logic elig [2];
      logic rst;
      int   g;
      @(posedge clk); #1;
      rst = !quiet && ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 2; i++) begin
         if (ackd_prev[i]) req[i] = 1'b0;
         if (!req[i] && !quiet && ($urandom_range(0, 2) == 0)) begin
            req[i]  = 1'b1;
            xwe[i]  = 1'($urandom_range(0, 1));
            xadr[i] = 16'($urandom_range(0, 63));
            xdat[i] = 16'($urandom);
         end else if (req[i] && !pend[i] && !quiet && ($urandom_range(0, 39) == 0)) begin
            req[i] = 1'b0;
         end
      end
      c_re = 1'b0; c_we = 1'b0;
      c_adr = 16'($urandom_range(0, 63));
      c_dat_o = 16'($urandom);
      if (!core_prev && !quiet && ($urandom_range(0, 1) == 0)) begin
         if ($urandom_range(0, 1) == 0) c_re = 1'b1; else c_we = 1'b1;
      end
      core_prev = c_re | c_we;
      reset = rst;

      // Acks due this cycle survive only if reset is not asserted.
      for (int i = 0; i < 2; i++) begin
         ackd_prev[i] = 1'b0;
         if (pend[i] && !rst) begin
            r.cyc = cyc; r.rd = ~xwe[i]; r.dat = shadow[xadr[i][5:0]];
            if (i == 0) a_q.push_back(r); else b_q.push_back(r);
            ackd_prev[i] = 1'b1;
         end
         elig[i] = req[i] && !pend[i];
      end
      pend[0] = 1'b0; pend[1] = 1'b0;
      if (rst) begin
         rr = 1'b0;
      end else if (c_re || c_we) begin
         push_bus(2'd1, c_re, c_we, c_adr, c_dat_o);
         if (c_re) begin
            r.cyc = cyc + 1; r.rd = 1'b1; r.dat = shadow[c_adr[5:0]];
            c_q.push_back(r);
         end
      end else begin
         g = -1;
         if (elig[0] && elig[1]) begin
            g = rr ? 1 : 0;
            rr = ~rr;
         end else if (elig[0]) g = 0;
         else if (elig[1]) g = 1;
         if (g >= 0) begin
            push_bus(2'(g + 2), ~xwe[g], xwe[g], xadr[g], xdat[g]);
            pend[g] = 1'b1;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem[i]    = 16'(i * 977) ^ 16'h5a5a;
         shadow[i] = 16'(i * 977) ^ 16'h5a5a;
      end
      for (int i = 0; i < 2; i++) begin
         req[i] = 1'b0; xwe[i] = 1'b0; xadr[i] = 16'h0; xdat[i] = 16'h0;
         pend[i] = 1'b0; ackd_prev[i] = 1'b0;
      end
      rr = 1'b0; core_prev = 1'b0;
      c_re = 1'b0; c_we = 1'b0; c_adr = 16'h0; c_dat_o = 16'h0;
      reset = 1'b1;
      req[0] = 1'b1; req[1] = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_m_re", {31'h0, m_re}, 32'h0);
      chk("reset_m_we", {31'h0, m_we}, 32'h0);
      chk("reset_owner", {30'h0, m_owner}, 32'h0);
      chk("reset_acks", {30'h0, a_ack, b_ack}, 32'h0);
      req[0] = 1'b0; req[1] = 1'b0;
      run = 1'b1;
      for (int n = 0; n < 4000; n++) step(1'b0);
      for (int n = 0; n < 12; n++) step(1'b1);
      @(negedge clk);
      @(negedge clk);
      chk("drain", bus_q.size() + a_q.size() + b_q.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
